// File: rtl/tx_deframer.sv
// ---------------------------------------------------------------------------
// tx_deframer
//
// Pulls 3-byte frames (header, MSB, LSB) out of a first-word-fall-through
// FIFO and presents each payload on a valid/ready output.
// Header byte layout: {SYNC_NIBBLE, 2'b00, chan[1:0]}.
//
// A header that does not match is dropped and flagged with a one-cycle
// sync_err pulse. If a frame stalls too long between bytes, the partial
// frame is dropped and sync_err is pulsed.
//
// Optional feature:
//   TX_DEFRAMER_ERRCNT_EN - when defined, adds the err_count port, which is a
//                           saturating count of sync_err pulses.
//
// Parameters
//   SYNC_NIBBLE  required value of header bits [7:4]
//   TIMEOUT      maximum clk cycles allowed between bytes of a frame (1..65535)
//   ERR_W        width of err_count
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   fifo_rdata   FIFO head byte, valid while fifo_rempty=0
//   fifo_rempty  FIFO empty flag
//   fifo_rinc    pop strobe, one byte per cycle high
//   out_data     frame payload {MSB,LSB}
//   out_chan     channel index from the header
//   out_valid    frame available, held until accepted
//   out_ready    consumer accept
//   sync_err     one-cycle pulse per framing error
//   busy         high whenever the machine is not waiting for a header
//   err_count    saturating error count (TX_DEFRAMER_ERRCNT_EN only)
// ---------------------------------------------------------------------------
module tx_deframer #(
  parameter logic [3:0] SYNC_NIBBLE = 4'hA,
  parameter int         TIMEOUT     = 1000,
  parameter int         ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic [15:0]      out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic             busy
`ifdef TX_DEFRAMER_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    MSB = 2'd1,
    LSB = 2'd2,
    OUT = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] timer_r;
  logic [15:0] timer_nxt_s;
  logic [15:0] timer_inc_s;
  logic        pop_s;
  logic        hdr_ok_s;
  logic        err_evt_s;
  logic        ld_chan_s;
  logic        ld_msb_s;
  logic        ld_lsb_s;
  logic [15:0] data_r;
  logic [1:0]  chan_r;
  logic        out_valid_r;
  logic        busy_r;
  logic        sync_err_r;

  // Next-state, pop strobe, inter-byte timer and register load enables
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = 16'd0;
    err_evt_s   = 1'b0;
    ld_chan_s   = 1'b0;
    ld_msb_s    = 1'b0;
    ld_lsb_s    = 1'b0;
    timer_inc_s = timer_r + 16'd1;
    hdr_ok_s    = (fifo_rdata[7:2] == {SYNC_NIBBLE, 2'b00});

    // The pop strobe is combinational so a byte can be taken every cycle.
    // It is gated by rst so nothing is consumed while the block is in reset.
    if (!rst && (state_r != OUT) && !fifo_rempty) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    case (state_r)
      HDR: begin
        if (pop_s) begin
          if (hdr_ok_s) begin
            state_nxt_s = MSB;
            ld_chan_s   = 1'b1;
          end else begin
            state_nxt_s = HDR;
            err_evt_s   = 1'b1;
          end
        end else begin
          state_nxt_s = HDR;
        end
      end
      MSB: begin
        if (pop_s) begin
          state_nxt_s = LSB;
          ld_msb_s    = 1'b1;
        end else if (fifo_rempty) begin
          // Give up on the partial frame once the gap reaches TIMEOUT.
          if (timer_inc_s == TIMEOUT_C) begin
            state_nxt_s = HDR;
            err_evt_s   = 1'b1;
          end else begin
            state_nxt_s = MSB;
            timer_nxt_s = timer_inc_s;
          end
        end else begin
          state_nxt_s = MSB;
          timer_nxt_s = timer_r;
        end
      end
      LSB: begin
        if (pop_s) begin
          state_nxt_s = OUT;
          ld_lsb_s    = 1'b1;
        end else if (fifo_rempty) begin
          if (timer_inc_s == TIMEOUT_C) begin
            state_nxt_s = HDR;
            err_evt_s   = 1'b1;
          end else begin
            state_nxt_s = LSB;
            timer_nxt_s = timer_inc_s;
          end
        end else begin
          state_nxt_s = LSB;
          timer_nxt_s = timer_r;
        end
      end
      OUT: begin
        // Waiting on the consumer does not count as a gap between bytes.
        if (out_ready) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = HDR;
      end
    endcase
  end

  // State, timer, payload/channel capture and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HDR;
      timer_r     <= 16'd0;
      data_r      <= 16'h0000;
      chan_r      <= 2'b00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      sync_err_r  <= err_evt_s;
      out_valid_r <= (state_nxt_s == OUT);
      busy_r      <= (state_nxt_s != HDR);
      if (ld_chan_s) begin
        chan_r <= fifo_rdata[1:0];
      end
      if (ld_msb_s) begin
        data_r[15:8] <= fifo_rdata;
      end
      if (ld_lsb_s) begin
        data_r[7:0] <= fifo_rdata;
      end
    end
  end

  assign fifo_rinc = pop_s;
  assign out_data  = data_r;
  assign out_chan  = chan_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sync_err  = sync_err_r;

`ifdef TX_DEFRAMER_ERRCNT_EN
  logic [ERR_W-1:0] err_count_r;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating count of error events, updated with the sync_err pulse itself
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {ERR_W{1'b0}};
    end else if (err_evt_s) begin
      err_count_r <= sat_inc(err_count_r);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_tx_deframer.sv
module tb_tx_deframer;

  localparam int TO    = 8;
  localparam int ERR_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;
  logic        busy;
`ifdef TX_DEFRAMER_ERRCNT_EN
  logic [ERR_W-1:0] err_count;
`endif

  always #5 clk = ~clk;

  tx_deframer #(
    .SYNC_NIBBLE(4'hA),
    .TIMEOUT    (TO),
    .ERR_W      (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc  (fifo_rinc),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sync_err   (sync_err),
    .busy       (busy)
`ifdef TX_DEFRAMER_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  typedef struct packed {
    logic        is_err;
    logic [1:0]  chan;
    logic [15:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];

  int n_checks      = 0;
  int n_errors      = 0;
  int cyc           = 0;
  int errs_seen     = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc  = -1;
  int first_rise_cyc = -1;
  int last_err_cyc  = -1;

  logic        stall       = 1'b0;
  logic        prev_valid  = 1'b0;
  logic        prev_accept = 1'b0;
  logic        rst_prev    = 1'b0;
  logic [15:0] held_data   = 16'h0000;
  logic [1:0]  held_chan   = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_frame(input logic [1:0] chan, input logic [15:0] data);
    exp_t e;
    e.is_err = 1'b0;
    e.chan   = chan;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.chan   = 2'b00;
    e.data   = 16'h0000;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs at the negedge, observe mid-cycle, then
  // retire the FIFO head if the DUT popped it on the rising edge.
  task automatic step();
    logic       will_pop;
    logic [7:0] dropped;
    exp_t       e;
    fifo_rempty = stall || (fifo_q.size() == 0);
    fifo_rdata  = fifo_rempty ? 8'h00 : fifo_q[0];
    #1;
    will_pop = fifo_rinc;
    if (rst) begin
      if (rst_prev) begin
        check_eq("rst_rinc", 32'(fifo_rinc), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sync_err", 32'(sync_err), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'h0000);
        check_eq("rst_chan", 32'(out_chan), 32'd0);
`ifdef TX_DEFRAMER_ERRCNT_EN
        check_eq("rst_err_count", 32'(err_count), 32'd0);
`endif
      end
      prev_valid  = 1'b0;
      prev_accept = 1'b0;
    end else begin
      if (fifo_rinc) begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (out_valid) check_eq("rinc_in_out", 32'(fifo_rinc), 32'd0);
      if (out_valid && !prev_valid && first_rise_cyc < 0) first_rise_cyc = cyc;
      if (out_valid && prev_valid && !prev_accept) begin
        check_eq("hold_data", 32'(out_data), 32'(held_data));
        check_eq("hold_chan", 32'(out_chan), 32'(held_chan));
      end
      if (sync_err) begin
        errs_seen++;
        last_err_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_err", 32'(sync_err), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("err_order", 32'(sync_err), 32'(e.is_err));
        end
`ifdef TX_DEFRAMER_ERRCNT_EN
        check_eq("err_count", 32'(err_count), (errs_seen > 3) ? 32'd3 : 32'(errs_seen));
`endif
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("frame_order", 32'(e.is_err), 32'd0);
          check_eq("frame_chan", 32'(out_chan), 32'(e.chan));
          check_eq("frame_data", 32'(out_data), 32'(e.data));
        end
      end
      prev_valid  = out_valid;
      prev_accept = out_valid && out_ready;
      held_data   = out_data;
      held_chan   = out_chan;
    end
    rst_prev = rst;
    @(posedge clk);
    if (will_pop && fifo_q.size() != 0) dropped = fifo_q.pop_front();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 200;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && budget > 0) begin
      step();
      budget--;
    end
    run(2);
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b1;
    fifo_rdata  = 8'h00;
    fifo_rempty = 1'b1;
    @(negedge clk);

    // Reset with A1 12 34 already waiting, then the basic frame and latency
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    expect_frame(2'd1, 16'h1234);
    run(3);
    rst = 1'b0;
    drain("basic");
    check_eq("latency", 32'(first_rise_cyc - first_pop_cyc), 32'd3);

    // Bad header followed by a good frame
    fifo_q.push_back(8'h55); fifo_q.push_back(8'hA0);
    fifo_q.push_back(8'hBE); fifo_q.push_back(8'hEF);
    expect_err();
    expect_frame(2'd0, 16'hBEEF);
    drain("bad_hdr");

    // Header then starvation: timeout after TO idle cycles
    fifo_q.push_back(8'hA2);
    expect_err();
    run(14);
    check_eq("timeout_gap", 32'(last_err_cyc - last_pop_cyc), 32'(TO + 1));
    check_eq("timeout_busy", 32'(busy), 32'd0);
    fifo_q.push_back(8'hA2); fifo_q.push_back(8'h00); fifo_q.push_back(8'h07);
    expect_frame(2'd2, 16'h0007);
    drain("after_timeout");

    // A gap of TO-1 idle cycles before the LSB must not time out
    fifo_q.push_back(8'hA0); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    expect_frame(2'd0, 16'h1122);
    run(2);
    stall = 1'b1;
    run(TO - 1);
    stall = 1'b0;
    drain("gap_edge");

    // Back-pressure: two frames queued, consumer stalled for 20 cycles
    out_ready = 1'b0;
    fifo_q.push_back(8'hA0); fifo_q.push_back(8'h00); fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'h00); fifo_q.push_back(8'h02);
    expect_frame(2'd0, 16'h0001);
    expect_frame(2'd1, 16'h0002);
    run(20);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_data", 32'(out_data), 32'h0001);
    check_eq("bp_chan", 32'(out_chan), 32'd0);
    check_eq("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
    out_ready = 1'b1;
    drain("backpressure");

    // Reset mid-frame after the MSB pop, then a channel-3 frame
    fifo_q.push_back(8'hA3); fifo_q.push_back(8'hFF);
    run(3);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    fifo_q.push_back(8'hA3); fifo_q.push_back(8'h00); fifo_q.push_back(8'h09);
    expect_frame(2'd3, 16'h0009);
    drain("after_rst");

    // Five bad headers (including non-zero bits [3:2]) then a good frame
    fifo_q.push_back(8'hA4); fifo_q.push_back(8'hA8); fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hB0); fifo_q.push_back(8'h0A);
    for (int i = 0; i < 5; i++) expect_err();
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'hCA); fifo_q.push_back(8'hFE);
    expect_frame(2'd1, 16'hCAFE);
    drain("bad_burst");
    check_eq("total_errs", 32'(errs_seen), 32'd7);
`ifdef TX_DEFRAMER_ERRCNT_EN
    check_eq("err_sat", 32'(err_count), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
